fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
Sequences instruction fetch for the CPU. It owns the 64-bit PC and reads each 32-bit instruction as four byte reads from the byte-wide instruction memory port, assembling them little-endian. It presents the instruction to decode with a valid/ready handshake and applies the branch redirect when the instruction is consumed. It stops fetching on the HALT opcode (bits [31:21] all ones) or on an address fault.

Parameters:
PC_W, 64, PC and memory address width in bits
IMEM_BYTES, 4096, instruction memory size in bytes; legal PCs are 0..IMEM_BYTES-4
RESET_PC, 0, PC value loaded on reset; must be a multiple of 4

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous, active-low reset
fetch_en  in  1  permits a new instruction fetch to start
mem_req  out  1  byte read request to instruction memory
mem_addr  out  PC_W  byte address of the current request
mem_ack  in  1  request accepted; mem_rdata is valid in this cycle
mem_rdata  in  8  read byte
inst  out  32  assembled instruction
inst_pc  out  PC_W  address of inst
inst_valid  out  1  inst/inst_pc valid for decode
inst_ready  in  1  decode accepts inst
br_taken  in  1  sampled on consume: redirect to br_target
br_target  in  PC_W  redirect byte address
halted  out  1  HALT consumed; fetch stopped
fault  out  1  out-of-range or misaligned PC; fetch stopped

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, inst=0, inst_pc=RESET_PC, inst_valid=0, mem_req=0, mem_addr=RESET_PC, halted=0, fault=0. Asserting reset mid-fetch drops mem_req immediately and discards partial bytes.
- States: IDLE, B0, B1, B2, B3, VALID, HALTED, FAULT.
- IDLE: if fetch_en=1, check pc. If pc[1:0]!=0 or pc>IMEM_BYTES-4, go to FAULT. Otherwise go to B0. If fetch_en=0, stay in IDLE.
- Bk (k=0..3): mem_req=1, mem_addr=pc+k. Hold both stable until mem_ack. On mem_ack, write mem_rdata into inst[8k+7:8k] and advance to B(k+1), or from B3 to VALID. A zero-wait memory (ack in the same cycle as req) gives 4 cycles of byte reads per instruction. mem_req deasserts in VALID.
- VALID: inst_valid=1 and inst_pc=pc. inst and inst_pc stay stable until consumed (inst_valid & inst_ready on a rising edge).
- On consume, evaluated in this priority order:
  - if inst[31:21]==11'h7FF: go to HALTED, set halted=1, ignore br_taken.
  - else if br_taken: pc<=br_target.
  - else: pc<=pc+4, wrapping mod 2^PC_W.
  - Next state is IDLE. When fetch_en=1, the next instruction's B0 request is issued the cycle after IDLE. Zero-wait throughput is 6 cycles per instruction.
- br_taken is ignored when no consume occurs in that cycle.
- fetch_en is sampled only in IDLE. Deasserting it mid-instruction does not abort the fetch.
- HALTED and FAULT are terminal until reset. In both: mem_req=0 and inst_valid=0. Also fault=1 in FAULT.
- FAULT after a consume: the bad pc is kept in pc and is visible on mem_addr; no memory request is issued.

Optional Feature:
FETCH_PERF_CNT_EN: when defined, adds outputs perf_inst (32 bits) and perf_stall (32 bits). perf_inst counts consumes, including the HALT consume. perf_stall counts cycles in VALID with inst_ready=0 plus cycles in Bk with mem_ack=0. Both reset to 0 and saturate at 2^32-1. When undefined, neither port nor counter exists and behaviour is otherwise identical.

Test Plan:
- Zero-wait memory loaded with bytes 78 56 34 12 at address 0, fetch_en=1, inst_ready=1 -> inst=32'h12345678, inst_pc=0; the next mem_addr sequence is 4,5,6,7; 6 cycles between consumes.
- inst_ready held low 5 cycles in VALID -> inst, inst_pc and inst_valid stay stable, mem_req=0; the first request after release is addressed to pc+4.
- Consume at pc=0x8 with br_taken=1, br_target=0x40 -> next requests go to 0x40..0x43; br_taken=1 pulsed while not consuming has no effect.
- Instruction 32'hFFE00000 consumed -> halted=1 the next cycle, mem_req stays 0 forever, later br_taken is ignored.
- Branch target 0x42, then in a separate run target 0x1000 with IMEM_BYTES=4096 -> fault=1, no mem_req, pc holds 0x42 or 0x1000 respectively.
- rst_n pulsed low during B2 with mem_ack withheld -> mem_req=0 immediately; after release the fetch restarts at RESET_PC with all outputs at their reset values.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, assembles 32-bit instructions from four byte reads,
// hands them to decode with valid/ready. Optional perf counters under FETCH_PERF_CNT_EN.
module fetch_sequencer #(
  parameter int              PC_W       = 64,
  parameter int              IMEM_BYTES = 4096,
  parameter logic [PC_W-1:0] RESET_PC   = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fetch_en,
  output logic            mem_req,
  output logic [PC_W-1:0] mem_addr,
  input  logic            mem_ack,
  input  logic [7:0]      mem_rdata,
  output logic [31:0]     inst,
  output logic [PC_W-1:0] inst_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  output logic            halted,
  output logic            fault
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_inst,
  output logic [31:0]     perf_stall
`endif
);

  typedef enum logic [2:0] {IDLE, B0, B1, B2, B3, VALID, HALTED, FAULT} state_t;

  localparam logic [PC_W-1:0] PC_MAX = PC_W'(IMEM_BYTES - 4);

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc;
  logic [1:0]      byte_idx;
  logic            consume;
  logic            is_halt;

  assign is_halt    = (inst[31:21] == 11'h7FF);
  assign consume    = (state == VALID) && inst_ready;
  assign inst_valid = (state == VALID);
  assign inst_pc    = pc;
  assign halted     = (state == HALTED);
  assign fault      = (state == FAULT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    mem_req   = 1'b0;
    byte_idx  = 2'd0;
    unique case (state)
      IDLE: if (fetch_en) state_nxt = ((pc[1:0] != 2'b00) || (pc > PC_MAX)) ? FAULT : B0;
      B0: begin mem_req = 1'b1; byte_idx = 2'd0; if (mem_ack) state_nxt = B1;    end
      B1: begin mem_req = 1'b1; byte_idx = 2'd1; if (mem_ack) state_nxt = B2;    end
      B2: begin mem_req = 1'b1; byte_idx = 2'd2; if (mem_ack) state_nxt = B3;    end
      B3: begin mem_req = 1'b1; byte_idx = 2'd3; if (mem_ack) state_nxt = VALID; end
      VALID: if (inst_ready) state_nxt = is_halt ? HALTED : IDLE;
      HALTED: state_nxt = HALTED;
      FAULT:  state_nxt = FAULT;
      default: state_nxt = IDLE;
    endcase
    // Outside a byte phase the address shows the PC, so a faulting PC stays observable.
    mem_addr = mem_req ? (pc + PC_W'(byte_idx)) : pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc   <= RESET_PC;
      inst <= '0;
    end else begin
      if (mem_req && mem_ack)
        inst[{byte_idx, 3'b000} +: 8] <= mem_rdata;
      if (consume && !is_halt)
        pc <= br_taken ? br_target : (pc + PC_W'(4));
    end
  end

`ifdef FETCH_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_inst  <= '0;
      perf_stall <= '0;
    end else begin
      if (consume)
        perf_inst <= sat_inc(perf_inst);
      if (((state == VALID) && !inst_ready) || (mem_req && !mem_ack))
        perf_stall <= sat_inc(perf_stall);
    end
  end
`endif

endmodule
